// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor count, floor-number width, request-queue
// FSM states and scan-direction encodings.
package elevator_pkg;

  localparam int NUM_FLOORS = 10;
  localparam int FLOOR_W    = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SELECT      = 2'd1,
    OFFER       = 2'd2,
    WAIT_ARRIVE = 2'd3
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/btn_conditioner.sv
// One call-button conditioner: 2-flop synchroniser, optional debounce and a
// registered rising-edge pulse. Optional feature macro: FLOOR_REQ_DEBOUNCE_EN
// (adds the DEBOUNCE_CYCLES stable-high counter).
module btn_conditioner
  import elevator_pkg::*;
`ifdef FLOOR_REQ_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic level;
  logic level_prev_q;
  logic rise_q;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef FLOOR_REQ_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  // Count consecutive high samples; any low sample restarts, saturate at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (!sync2_q) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign level = (cnt_q == CNT_MAX);
`else
  assign level = sync2_q;
`endif

  // Registered rising edge of the conditioned level, so a held button fires once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_prev_q <= 1'b0;
      rise_q       <= 1'b0;
    end else begin
      level_prev_q <= level;
      rise_q       <= level & ~level_prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/floor_request_queue.sv
// Floor request queue: latches conditioned call buttons into a pending bitmap
// and offers one SCAN-ordered target at a time to the elevator FSM.
// Optional feature macro: FLOOR_REQ_DEBOUNCE_EN (per-button debounce).
module floor_request_queue
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
`ifdef FLOOR_REQ_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  arrived,
  output logic [FLOOR_W-1:0]    tgt_floor,
  output logic                  tgt_valid,
  input  logic                  tgt_ready,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up
);

  localparam logic [FLOOR_W:0] FLOOR_LIMIT = (FLOOR_W+1)'(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] rise;
  logic [NUM_FLOORS-1:0] clr_mask;
  logic [NUM_FLOORS-1:0] sel_mask;
  logic [NUM_FLOORS-1:0] pending_q;
  logic [NUM_FLOORS-1:0] pending_d;
  logic                  cur_in_range;

  state_e                state_q;
  logic [FLOOR_W-1:0]    tgt_floor_q;
  logic                  tgt_valid_q;
  logic                  dir_up_q;

  logic                  up_found;
  logic                  dn_found;
  logic [FLOOR_W-1:0]    up_idx;
  logic [FLOOR_W-1:0]    dn_idx;
  logic [FLOOR_W-1:0]    low_idx;
  logic [FLOOR_W-1:0]    sel_tgt;
  logic                  sel_dir;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_btn
`ifdef FLOOR_REQ_DEBOUNCE_EN
      btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
`else
      btn_conditioner u_cond (
`endif
        .clk   (clk),
        .reset (reset),
        .btn_i (btn[gi]),
        .rise_o(rise[gi])
      );
    end
  endgenerate

  assign cur_in_range = ({1'b0, cur_floor} < FLOOR_LIMIT);

  // Arrival clears the reported floor; out-of-range floors clear nothing.
  always_comb begin
    clr_mask = '0;
    if (arrived && cur_in_range) begin
      clr_mask[cur_floor] = 1'b1;
    end
    pending_d = (pending_q | rise) & ~clr_mask;
    sel_mask  = pending_q & ~clr_mask;
  end

  // Pending-request bitmap; a clear in the same cycle as a set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // SCAN candidates: nearest above, nearest below and lowest overall.
  always_comb begin
    up_found = 1'b0;
    dn_found = 1'b0;
    up_idx   = '0;
    dn_idx   = '0;
    low_idx  = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (sel_mask[i]) begin
        low_idx = FLOOR_W'(i);
        if (i > int'(cur_floor)) begin
          up_found = 1'b1;
          up_idx   = FLOOR_W'(i);
        end
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (sel_mask[i] && (i < int'(cur_floor))) begin
        dn_found = 1'b1;
        dn_idx   = FLOOR_W'(i);
      end
    end
    sel_dir = dir_up_q;
    sel_tgt = '0;
    if (!cur_in_range) begin
      sel_tgt = low_idx;
      sel_dir = DIR_UP;
    end else if (sel_mask[cur_floor]) begin
      sel_tgt = cur_floor;
    end else if (dir_up_q == DIR_UP) begin
      if (up_found) begin
        sel_tgt = up_idx;
      end else begin
        sel_tgt = dn_idx;
        sel_dir = DIR_DOWN;
      end
    end else begin
      if (dn_found) begin
        sel_tgt = dn_idx;
      end else begin
        sel_tgt = up_idx;
        sel_dir = DIR_UP;
      end
    end
  end

  // Target FSM with registered handshake outputs and scan direction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tgt_floor_q <= '0;
      tgt_valid_q <= 1'b0;
      dir_up_q    <= DIR_UP;
    end else begin
      case (state_q)
        IDLE: begin
          if (pending_q != '0) begin
            state_q <= SELECT;
          end
        end
        SELECT: begin
          if (sel_mask == '0) begin
            state_q <= IDLE;
          end else begin
            tgt_floor_q <= sel_tgt;
            dir_up_q    <= sel_dir;
            tgt_valid_q <= 1'b1;
            state_q     <= OFFER;
          end
        end
        OFFER: begin
          if (tgt_ready) begin
            tgt_valid_q <= 1'b0;
            state_q     <= WAIT_ARRIVE;
          end else if (arrived && (cur_floor == tgt_floor_q)) begin
            tgt_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        WAIT_ARRIVE: begin
          if (arrived && (cur_floor == tgt_floor_q)) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          tgt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pending   = pending_q;
  assign tgt_floor = tgt_floor_q;
  assign tgt_valid = tgt_valid_q;
  assign dir_up    = dir_up_q;

endmodule

// File: tb/tb_floor_request_queue.sv
// Directed bench for floor_request_queue: reset, single call, SCAN order,
// backpressure, set/clear collision, out-of-range floor, mid-trip reset and
// (with FLOOR_REQ_DEBOUNCE_EN) debounce.
module tb_floor_request_queue;

  // Clocks from driving btn (just after an edge) until pending shows the bit.
`ifdef FLOOR_REQ_DEBOUNCE_EN
  localparam int LAT = 16 + 4;
`else
  localparam int LAT = 4;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] btn;
  logic [3:0] cur_floor;
  logic       arrived;
  logic       tgt_ready;
  logic [3:0] tgt_floor;
  logic       tgt_valid;
  logic [9:0] pending;
  logic       dir_up;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  floor_request_queue dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .cur_floor(cur_floor),
    .arrived  (arrived),
    .tgt_floor(tgt_floor),
    .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready),
    .pending  (pending),
    .dir_up   (dir_up)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    btn       = '0;
    cur_floor = '0;
    arrived   = 1'b0;
    tgt_ready = 1'b0;
    ticks(2);
    reset = 1'b1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tgt_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic arrive_at(input logic [3:0] fl);
    cur_floor = fl;
    arrived   = 1'b1;
    tick();
    arrived   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; btn = 10'h3FF; cur_floor = '0; arrived = 1'b0; tgt_ready = 1'b0;
    ticks(2);
    total_cnt++; if (pending !== 10'h000) $display("FAIL reset_pending: got %h expected 000", pending); else pass_cnt++;
    total_cnt++; if (tgt_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", tgt_valid); else pass_cnt++;
    total_cnt++; if (dir_up !== 1'b1) $display("FAIL reset_dir: got %b expected 1", dir_up); else pass_cnt++;
    total_cnt++; if (tgt_floor !== 4'd0) $display("FAIL reset_tgt: got %0d expected 0", tgt_floor); else pass_cnt++;
    reset = 1'b1;
    ticks(LAT - 1);
    total_cnt++; if (pending !== 10'h000) $display("FAIL release_early: got %h expected 000", pending); else pass_cnt++;
    tick();
    total_cnt++; if (pending !== 10'h3FF) $display("FAIL release_all: got %h expected 3ff", pending); else pass_cnt++;
    ticks(4);
    arrive_at(4'd0);
    ticks(LAT + 2);
    total_cnt++; if (pending !== 10'h3FE) $display("FAIL held_once: got %h expected 3fe", pending); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_single_call();
    do_reset();
    cur_floor = 4'd0; tgt_ready = 1'b1; btn = 10'h002;
    ticks(LAT - 1);
    total_cnt++; if (pending !== 10'h000) $display("FAIL single_early: got %h expected 000", pending); else pass_cnt++;
    tick();
    total_cnt++; if (pending !== 10'h002) $display("FAIL single_set: got %h expected 002", pending); else pass_cnt++;
    tick();
    total_cnt++; if (tgt_valid !== 1'b0) $display("FAIL single_select_valid: got %b expected 0", tgt_valid); else pass_cnt++;
    tick();
    total_cnt++; if (tgt_valid !== 1'b1) $display("FAIL single_offer_valid: got %b expected 1", tgt_valid); else pass_cnt++;
    total_cnt++; if (tgt_floor !== 4'd1) $display("FAIL single_tgt: got %0d expected 1", tgt_floor); else pass_cnt++;
    tick();
    total_cnt++; if (tgt_valid !== 1'b0) $display("FAIL single_accept: got %b expected 0", tgt_valid); else pass_cnt++;
    btn = '0;
    arrive_at(4'd1);
    total_cnt++; if (pending !== 10'h000) $display("FAIL single_clear: got %h expected 000", pending); else pass_cnt++;
    ticks(3);
    total_cnt++; if (tgt_valid !== 1'b0) $display("FAIL single_idle: got %b expected 0", tgt_valid); else pass_cnt++;
    $display("test_single_call done");
  endtask

  task automatic test_scan_order();
    logic [3:0] exp_tgt [3];
    logic       exp_dir [3];
    logic [9:0] exp_pend[3];
    bit ok;
    exp_tgt  = '{4'd8, 4'd3, 4'd1};
    exp_dir  = '{1'b1, 1'b0, 1'b0};
    exp_pend = '{10'h00A, 10'h002, 10'h000};
    do_reset();
    cur_floor = 4'd4; tgt_ready = 1'b1; btn = 10'h10A;
    ticks(LAT);
    total_cnt++; if (pending !== 10'h10A) $display("FAIL scan_pending: got %h expected 10a", pending); else pass_cnt++;
    btn = '0;
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok);
      total_cnt++; if (!ok) $display("FAIL scan_timeout[%0d]: got no tgt_valid expected tgt_valid", k); else pass_cnt++;
      total_cnt++; if (tgt_floor !== exp_tgt[k]) $display("FAIL scan_tgt[%0d]: got %0d expected %0d", k, tgt_floor, exp_tgt[k]); else pass_cnt++;
      total_cnt++; if (dir_up !== exp_dir[k]) $display("FAIL scan_dir[%0d]: got %b expected %b", k, dir_up, exp_dir[k]); else pass_cnt++;
      tick();
      arrive_at(exp_tgt[k]);
      total_cnt++; if (pending !== exp_pend[k]) $display("FAIL scan_pend[%0d]: got %h expected %h", k, pending, exp_pend[k]); else pass_cnt++;
      $display("scan trip %0d target %0d dir_up %b", k, tgt_floor, dir_up);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    cur_floor = 4'd0; tgt_ready = 1'b0; btn = 10'h040;
    wait_valid(ok);
    total_cnt++; if (!ok) $display("FAIL bp_timeout: got no tgt_valid expected tgt_valid"); else pass_cnt++;
    total_cnt++; if (tgt_floor !== 4'd6) $display("FAIL bp_tgt: got %0d expected 6", tgt_floor); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      tick();
      total_cnt++;
      if ({tgt_valid, tgt_floor} !== {1'b1, 4'd6})
        $display("FAIL bp_hold[%0d]: got valid=%b tgt=%0d expected valid=1 tgt=6", k, tgt_valid, tgt_floor);
      else pass_cnt++;
    end
    tgt_ready = 1'b1;
    tick();
    total_cnt++; if (tgt_valid !== 1'b0) $display("FAIL bp_accept: got %b expected 0", tgt_valid); else pass_cnt++;
    ticks(3);
    total_cnt++; if (tgt_valid !== 1'b0) $display("FAIL bp_no_retarget: got %b expected 0", tgt_valid); else pass_cnt++;
    btn = '0;
    $display("test_backpressure done");
  endtask

  task automatic test_set_clear();
    do_reset();
    btn = 10'h004;
    ticks(LAT - 1);
    cur_floor = 4'd2; arrived = 1'b1;
    tick();
    arrived = 1'b0;
    total_cnt++; if (pending !== 10'h000) $display("FAIL setclr_pending: got %h expected 000", pending); else pass_cnt++;
    ticks(LAT);
    total_cnt++; if ({pending, tgt_valid} !== 11'h000) $display("FAIL setclr_quiet: got pending=%h valid=%b expected 000/0", pending, tgt_valid); else pass_cnt++;
    btn = '0;
    $display("test_set_clear done");
  endtask

  task automatic test_out_of_range();
    bit ok;
    do_reset();
    cur_floor = 4'd15; tgt_ready = 1'b0; btn = 10'h200;
    wait_valid(ok);
    total_cnt++; if (!ok) $display("FAIL oor_timeout: got no tgt_valid expected tgt_valid"); else pass_cnt++;
    total_cnt++; if (tgt_floor !== 4'd9) $display("FAIL oor_tgt: got %0d expected 9", tgt_floor); else pass_cnt++;
    total_cnt++; if (dir_up !== 1'b1) $display("FAIL oor_dir: got %b expected 1", dir_up); else pass_cnt++;
    arrive_at(4'd15);
    total_cnt++; if (pending !== 10'h200) $display("FAIL oor_ignore: got %h expected 200", pending); else pass_cnt++;
    total_cnt++; if (tgt_valid !== 1'b1) $display("FAIL oor_offer_kept: got %b expected 1", tgt_valid); else pass_cnt++;
    btn = '0;
    $display("test_out_of_range done");
  endtask

  task automatic test_reset_mid_trip();
    bit ok;
    do_reset();
    cur_floor = 4'd2; tgt_ready = 1'b1; btn = 10'h001;
    wait_valid(ok);
    total_cnt++; if (!ok) $display("FAIL mid_timeout: got no tgt_valid expected tgt_valid"); else pass_cnt++;
    total_cnt++; if ({tgt_floor, dir_up} !== {4'd0, 1'b0}) $display("FAIL mid_select: got tgt=%0d dir=%b expected tgt=0 dir=0", tgt_floor, dir_up); else pass_cnt++;
    tick();
    btn = 10'h011;
    ticks(LAT);
    total_cnt++; if (pending !== 10'h011) $display("FAIL mid_pending: got %h expected 011", pending); else pass_cnt++;
    total_cnt++; if (tgt_valid !== 1'b0) $display("FAIL mid_wait: got %b expected 0", tgt_valid); else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total_cnt++; if (pending !== 10'h000) $display("FAIL mid_rst_pending: got %h expected 000", pending); else pass_cnt++;
    total_cnt++; if (dir_up !== 1'b1) $display("FAIL mid_rst_dir: got %b expected 1", dir_up); else pass_cnt++;
    total_cnt++; if ({tgt_valid, tgt_floor} !== 5'h00) $display("FAIL mid_rst_tgt: got valid=%b tgt=%0d expected 0/0", tgt_valid, tgt_floor); else pass_cnt++;
    btn = '0;
    $display("test_reset_mid_trip done");
  endtask

`ifdef FLOOR_REQ_DEBOUNCE_EN
  task automatic test_debounce();
    do_reset();
    btn = 10'h020;
    ticks(10);
    btn = '0;
    ticks(3);
    total_cnt++; if (pending !== 10'h000) $display("FAIL deb_short: got %h expected 000", pending); else pass_cnt++;
    btn = 10'h020;
    ticks(LAT - 1);
    total_cnt++; if (pending !== 10'h000) $display("FAIL deb_early: got %h expected 000", pending); else pass_cnt++;
    tick();
    total_cnt++; if (pending !== 10'h020) $display("FAIL deb_set: got %h expected 020", pending); else pass_cnt++;
    ticks(4);
    arrive_at(4'd5);
    ticks(25);
    total_cnt++; if (pending !== 10'h000) $display("FAIL deb_once: got %h expected 000", pending); else pass_cnt++;
    btn = '0;
    $display("test_debounce done");
  endtask
`endif

  initial begin
    test_reset();
    test_single_call();
    test_scan_order();
    test_backpressure();
    test_set_clear();
    test_out_of_range();
    test_reset_mid_trip();
`ifdef FLOOR_REQ_DEBOUNCE_EN
    test_debounce();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/floor_request_queue.md
Name: floor_request_queue

Overview:
Upstream request stage for the elevator FSM. Conditions the raw floor call buttons, latches them into a pending-request bitmap, and selects the next target floor with a SCAN policy. Continues in the current travel direction first, then reverses. Hands one target at a time to the elevator FSM over a valid/ready handshake; the FSM returns its current floor and an arrival pulse.

Parameters:
NUM_FLOORS, 10, number of floors / call buttons (index 0 = ground)
FLOOR_W, 4, width of floor numbers; must satisfy 2**FLOOR_W >= NUM_FLOORS
DEBOUNCE_CYCLES, 16, stable-high clocks required per button (used only with DEBOUNCE_EN)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
btn  input  NUM_FLOORS  raw call buttons; bit i = floor i; asynchronous to clk
cur_floor  input  FLOOR_W  current floor reported by the elevator FSM
arrived  input  1  1-cycle pulse from the FSM: car stopped at cur_floor
tgt_floor  output  FLOOR_W  selected target floor
tgt_valid  output  1  tgt_floor is offered to the FSM
tgt_ready  input  1  FSM accepts the target when tgt_valid && tgt_ready
pending  output  NUM_FLOORS  registered pending-request bitmap
dir_up  output  1  current scan direction (1 = up, 0 = down)

Behaviour:
- Reset (reset=0, async): pending=0, tgt_valid=0, tgt_floor=0, dir_up=1, state=IDLE, and all synchroniser/edge/debounce flops = 0. A reset mid-operation discards every queued request.
- Conditioning (no DEBOUNCE_EN): 2-flop synchroniser, then rising-edge detect. pending[i] is set 3 clocks after btn[i] is first sampled high. A held button sets the bit only once.
- Clear: arrived clears pending[cur_floor]. If the same bit is set and cleared in the same cycle, clear wins.
- arrived with cur_floor >= NUM_FLOORS is ignored.
- FSM states: IDLE, SELECT, OFFER, WAIT_ARRIVE.
- IDLE: stays while pending==0; otherwise goes to SELECT next cycle.
- SELECT (exactly 1 cycle): the target is chosen in this order:
  - If pending[cur_floor] is set, target = cur_floor.
  - Else if dir_up: lowest pending index > cur_floor. If none, dir_up<=0 and target = highest pending index < cur_floor.
  - Else (down): highest pending index < cur_floor. If none, dir_up<=1 and target = lowest pending index > cur_floor.
  - If cur_floor >= NUM_FLOORS: target = lowest pending index, dir_up<=1.
  - If pending became 0 (cleared in that cycle): return to IDLE.
  - Otherwise register tgt_floor and go to OFFER.
- OFFER: tgt_valid=1.
  - tgt_floor must stay stable until the handshake completes.
  - On tgt_valid && tgt_ready: tgt_valid<=0 and go to WAIT_ARRIVE.
  - If arrived at tgt_floor occurs before acceptance: drop the offer (tgt_valid<=0) and go to IDLE.
- WAIT_ARRIVE: no re-targeting.
  - arrived with cur_floor==tgt_floor: go to IDLE.
  - arrived at any other floor: clears that bit only and stays in WAIT_ARRIVE.
  - New requests keep being latched and are served at the next SELECT.
- Latency: in the idle case, tgt_valid asserts 2 clocks after a pending bit first appears (IDLE→SELECT→OFFER).
- pending is a direct register output; there is no combinational path from btn to any output.

Optional Feature:
FLOOR_REQ_DEBOUNCE_EN:
- Defined: each synchronised button must be high for DEBOUNCE_CYCLES consecutive clocks before its edge is accepted. Any low sample restarts the counter. pending[i] is set DEBOUNCE_CYCLES+3 clocks after the first high sample.
- Undefined: no debounce counter is built; latency is 3 clocks as above.

Decomposition:
- Shared package elevator_pkg holds:
  - NUM_FLOORS and FLOOR_W constants (shared with the elevator FSM and LED/display logic)
  - the state typedef {IDLE, SELECT, OFFER, WAIT_ARRIVE}
  - DIR_UP/DIR_DOWN constants
- One sub-module, btn_conditioner: synchroniser, edge detect and optional debounce for one button. Generated NUM_FLOORS times.
- Selection logic stays inline.

Test Plan:
- Reset: hold reset=0 with btn=10'h3FF -> pending=0, tgt_valid=0, dir_up=1. After release with btn held -> one edge per floor, pending=10'h3FF.
- Single call: cur_floor=0, btn[1] pulsed, tgt_ready=1 -> pending[1] set 3 clocks after sampling; tgt_floor=1, tgt_valid for 1 cycle; arrived with cur_floor=1 -> pending=0, state IDLE.
- SCAN order: cur_floor=4, dir_up=1, pending floors {3,8,1}; FSM completes each trip -> targets issued 8, 3, 1; dir_up goes to 0 after floor 8.
- Backpressure: tgt_ready=0 for 5 cycles -> tgt_valid held high, tgt_floor constant; tgt_ready=1 -> accepted in that cycle.
- Simultaneous set/clear: btn[2] edge reaches pending on the same cycle as arrived with cur_floor=2 -> pending[2]=0.
- Reset mid-trip: in WAIT_ARRIVE with pending=10'h011, reset asserted -> all outputs return to reset values asynchronously (before the next clk edge).
- Debounce (with FLOOR_REQ_DEBOUNCE_EN): btn[5] high 10 cycles, low, then high 20 cycles -> pending[5] set exactly once, 19 clocks after the second rise.
